ifu_fetch_way1: RTL and testbench



---
 rtl/ifu_fetch_way1.sv | 164 ++++++++++++++++
 tb/tb_ifu_fetch_way1.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_way1.sv
// Way1 instruction fetch: takes PC-unit fetch requests, issues one single-beat bus read at a time,
// and queues {pc, inst} pairs for way1 decode. A jump flushes the queue and discards any in-flight read.
// Latency: accept -> instValid_o is 3 cycles minimum (grant and rvalid each one cycle after request).
// Backpressure: ready_o is low while a fetch is in flight, while the queue is full, or during a jump.
// Ports:
//   PC unit : request_i, valid_i, instAddr_i in; ready_o, dataOk_o out; jumpFlag_i redirect/flush.
//   Bus     : busReq_o, busAddr_o out; busGnt_i, busRvalid_i, busRdata_i in.
//   Decode  : instValid_o, inst_o, pc_o out (queue head); decReady_i pops the head.
module ifu_fetch_way1 #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              request_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] instAddr_i,
  output logic              ready_o,
  output logic              dataOk_o,
  input  logic              jumpFlag_i,
  output logic              busReq_o,
  output logic [ADDR_W-1:0] busAddr_o,
  input  logic              busGnt_i,
  input  logic              busRvalid_i,
  input  logic [INST_W-1:0] busRdata_i,
  output logic              instValid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              decReady_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              discard_q, discard_d;
  logic              dataok_q, dataok_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d   [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // Only one fetch in flight, so checking count at accept time reserves its queue slot.
  assign ready_o     = (state_q == ST_IDLE) && (count_q < FULL) && !jumpFlag_i;
  assign accept      = request_i && valid_i && ready_o;
  assign instValid_o = (count_q != '0);
  // A jump overrides both queue ports in the same cycle.
  assign pop         = instValid_o && decReady_i && !jumpFlag_i;
  assign push        = (state_q == ST_WAIT) && busRvalid_i && !discard_q && !jumpFlag_i;

  assign busReq_o  = (state_q == ST_REQ);
  assign busAddr_o = addr_q;
  assign dataOk_o  = dataok_q;
  assign inst_o    = inst_mem_q[rd_ptr_q];
  assign pc_o      = pc_mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          addr_d  = instAddr_i;
        end
      end
      ST_REQ: begin
        if (jumpFlag_i) begin
          // A grant in the jump cycle still owes us a response; swallow it in WAIT.
          if (busGnt_i) begin
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (busGnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (busRvalid_i) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
        end else if (jumpFlag_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dataok_d   = push;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (jumpFlag_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = busRdata_i;
        pc_mem_d[wr_ptr_q]   = addr_q;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      discard_q <= 1'b0;
      dataok_q  <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
      dataok_q   <= dataok_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (count_q == FULL)));

endmodule

// File: tb/tb_ifu_fetch_way1.sv
// Bench for ifu_fetch_way1: drives PC-unit and bus sides, scoreboard of expected {pc, inst} at decode.
// Inputs change on the falling edge; outputs are checked on the falling edge or just after it.
// Decode pops are checked by a monitor against the queue of expected entries.
module tb_ifu_fetch_way1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        request_i, valid_i, jumpFlag_i;
  logic [31:0] instAddr_i;
  logic        ready_o, dataOk_o, busReq_o, instValid_o;
  logic [31:0] busAddr_o, inst_o, pc_o;
  logic        busGnt_i, busRvalid_i, decReady_i;
  logic [31:0] busRdata_i;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ifu_fetch_way1 #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .request_i(request_i), .valid_i(valid_i), .instAddr_i(instAddr_i),
    .ready_o(ready_o), .dataOk_o(dataOk_o), .jumpFlag_i(jumpFlag_i),
    .busReq_o(busReq_o), .busAddr_o(busAddr_o), .busGnt_i(busGnt_i),
    .busRvalid_i(busRvalid_i), .busRdata_i(busRdata_i),
    .instValid_o(instValid_o), .inst_o(inst_o), .pc_o(pc_o), .decReady_i(decReady_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_for(input logic [31:0] a);
    return (a == 32'h4) ? 32'h0010_0093 : (a ^ 32'hDEAD_0000);
  endfunction

  // Decode-side monitor: every pop must match the oldest expected entry.
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (reset_n && !jumpFlag_i && instValid_o && decReady_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 64'(pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("head_pc", 64'(pc_o), 64'(e[63:32]));
        chk("head_inst", 64'(inst_o), 64'(e[31:0]));
      end
    end
  end

  // mode 0: normal, 1: jump in WAIT, 2: jump+pop on the rvalid cycle, 3: async reset in WAIT
  task automatic do_fetch(input logic [31:0] a, input int gstall, input int mode);
    int n;
    logic [31:0] d;
    d = inst_for(a);
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(ready_o), 64'd1);
    request_i = 1'b1; valid_i = 1'b1; instAddr_i = a;
    @(negedge clk);
    request_i = 1'b0; valid_i = 1'b0; instAddr_i = '0;
    for (int g = 0; g <= gstall; g++) begin
      chk("busreq_hi", 64'(busReq_o), 64'd1);
      chk("busaddr", 64'(busAddr_o), 64'(a));
      busGnt_i = (g == gstall);
      @(negedge clk);
    end
    busGnt_i = 1'b0;
    chk("busreq_lo", 64'(busReq_o), 64'd0);
    if (mode == 1) begin
      jumpFlag_i = 1'b1;
      exp_q.delete();
      @(negedge clk);
      jumpFlag_i = 1'b0;
      @(negedge clk);
    end
    if (mode == 3) begin
      #3 reset_n = 1'b0;
      #1;
      chk("rst_busreq", 64'(busReq_o), 64'd0);
      chk("rst_ivalid", 64'(instValid_o), 64'd0);
      chk("rst_dataok", 64'(dataOk_o), 64'd0);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
    end
    if (mode == 2) begin
      jumpFlag_i = 1'b1;
      decReady_i = 1'b1;
      exp_q.delete();
    end else if (mode == 0) begin
      exp_q.push_back({a, d});
    end
    @(negedge clk) ;
    if (mode == 2 || mode == 1 || mode == 3) begin end
    busRvalid_i = 1'b1; busRdata_i = d;
    if (mode == 2) begin end
    @(negedge clk);
    busRvalid_i = 1'b0; busRdata_i = '0;
    chk("dataok", 64'(dataOk_o), 64'(mode == 0));
    if (mode == 2) begin
      jumpFlag_i = 1'b0;
      decReady_i = 1'b0;
      chk("jump_empty", 64'(instValid_o), 64'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    request_i = 1'b0; valid_i = 1'b0; instAddr_i = '0; jumpFlag_i = 1'b0;
    busGnt_i = 1'b0; busRvalid_i = 1'b0; busRdata_i = '0; decReady_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busreq", 64'(busReq_o), 64'd0);
    chk("rst_busaddr", 64'(busAddr_o), 64'd0);
    chk("rst_dataok", 64'(dataOk_o), 64'd0);
    chk("rst_ivalid", 64'(instValid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_pc", 64'(pc_o), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);

    // single fetch, consumed immediately
    decReady_i = 1'b1;
    do_fetch(32'h4, 0, 0);
    @(negedge clk);
    chk("single_empty", 64'(instValid_o), 64'd0);
    chk("single_dataok_pulse", 64'(dataOk_o), 64'd0);
    drain();

    // back-pressure: fill the queue, then release
    decReady_i = 1'b0;
    do_fetch(32'h4, 0, 0);
    do_fetch(32'hC, 0, 0);
    do_fetch(32'h14, 0, 0);
    do_fetch(32'h1C, 0, 0);
    chk("full_ready", 64'(ready_o), 64'd0);
    chk("full_head", 64'(pc_o), 64'h4);
    decReady_i = 1'b1;
    @(negedge clk);
    decReady_i = 1'b0;
    chk("ready_back", 64'(ready_o), 64'd1);
    decReady_i = 1'b1;
    drain();

    // grant stall
    do_fetch(32'h40, 5, 0);
    drain();

    // jump during WAIT, then a clean fetch
    do_fetch(32'h80, 0, 1);
    chk("jw_empty", 64'(instValid_o), 64'd0);
    do_fetch(32'h100, 0, 0);
    drain();

    // jump with queued entries plus same-cycle push and pop
    decReady_i = 1'b0;
    do_fetch(32'h200, 0, 0);
    do_fetch(32'h204, 0, 0);
    do_fetch(32'h208, 0, 0);
    do_fetch(32'h20C, 0, 2);
    @(negedge clk);
    chk("jf_empty", 64'(instValid_o), 64'd0);
    decReady_i = 1'b1;
    do_fetch(32'h300, 0, 0);
    drain();

    // async reset mid-transaction, late rvalid ignored
    decReady_i = 1'b0;
    do_fetch(32'h400, 0, 0);
    do_fetch(32'h404, 0, 3);
    @(negedge clk);
    chk("rst_late_ivalid", 64'(instValid_o), 64'd0);
    chk("rst_late_ready", 64'(ready_o), 64'd1);
    decReady_i = 1'b1;
    do_fetch(32'h500, 0, 0);
    drain();
    @(negedge clk);
    chk("final_empty", 64'(instValid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
